spike_decoder: RTL and testbench

- Sits at the output end of the SNN datapath and consumes the spikes the neuron core emits.
- The neuron core is time-multiplexed, so spikes arrive one neuron per cycle with an index.
- The block counts spikes per output neuron over an inference window, then scans the counters for the winner (argmax).
- It presents the class index and winning count over a valid/ready handshake to the Wishbone/logic-analyzer readout.

---
 rtl/snn_pkg.sv | 15 +
 rtl/spike_counter_bank.sv | 61 ++++++
 rtl/spike_decoder.sv | 131 +++++++++++++
 tb/tb_spike_decoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN output stage: default sizes and decoder state encoding.
package snn_pkg;

  localparam int unsigned NUM_OUTPUTS_DEF = 10;
  localparam int unsigned IDX_W_DEF       = 4;
  localparam int unsigned CNT_W_DEF       = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StScan  = 2'd2,
    StDone  = 2'd3
  } dec_state_e;

endpackage

// File: rtl/spike_counter_bank.sv
// Bank of saturating per-neuron spike counters with a clear, an indexed increment and read port(s).
// SPIKE_DECODER_COUNT_READ_EN adds an independent debug read port.
module spike_counter_bank
  import snn_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS = NUM_OUTPUTS_DEF,
  parameter int unsigned IDX_W       = IDX_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [IDX_W-1:0] inc_idx,
  input  logic [IDX_W-1:0] scan_idx,
  output logic [CNT_W-1:0] scan_count
`ifdef SPIKE_DECODER_COUNT_READ_EN
  ,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [CNT_W-1:0] dbg_count
`endif
);

  logic [CNT_W-1:0] cnt_q [NUM_OUTPUTS];

  // Indices at or above NUM_OUTPUTS match no counter, so they are dropped here.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (inc) begin
      for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
        if ((32'(inc_idx) == i) && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    scan_count = '0;
    for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
      if (32'(scan_idx) == i) begin
        scan_count = cnt_q[i];
      end
    end
  end

`ifdef SPIKE_DECODER_COUNT_READ_EN
  always_comb begin
    dbg_count = '0;
    for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
      if (32'(dbg_idx) == i) begin
        dbg_count = cnt_q[i];
      end
    end
  end
`endif

endmodule

// File: rtl/spike_decoder.sv
// Spike-count argmax decoder: accumulates spikes per output neuron over a window, then scans
// for the winner. SPIKE_DECODER_COUNT_READ_EN exposes rd_idx_i/rd_count_o for histogram readout.
module spike_decoder
  import snn_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS = NUM_OUTPUTS_DEF,
  parameter int unsigned IDX_W       = IDX_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic             spike_valid_i,
  input  logic             spike_i,
  input  logic [IDX_W-1:0] spike_idx_i,
  input  logic             end_i,
  output logic             busy_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic [IDX_W-1:0] result_class_o,
  output logic [CNT_W-1:0] result_count_o
`ifdef SPIKE_DECODER_COUNT_READ_EN
  ,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0] rd_count_o
`endif
);

  // One extra bit so the pointer can reach NUM_OUTPUTS, which marks the scan as finished.
  localparam int unsigned PTR_W = IDX_W + 1;

  dec_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;

  logic             cnt_clear;
  logic             cnt_inc;
  logic [CNT_W-1:0] scan_count;

  spike_counter_bank #(
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .IDX_W       (IDX_W),
    .CNT_W       (CNT_W)
  ) u_bank (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .clear      (cnt_clear),
    .inc        (cnt_inc),
    .inc_idx    (spike_idx_i),
    .scan_idx   (ptr_q[IDX_W-1:0]),
    .scan_count (scan_count)
`ifdef SPIKE_DECODER_COUNT_READ_EN
    ,
    .dbg_idx    (rd_idx_i),
    .dbg_count  (rd_count_o)
`endif
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;

    if (start_i) begin
      // Start overrides everything, including a coincident end_i.
      state_d    = StAccum;
      cnt_clear  = 1'b1;
      ptr_d      = '0;
      best_idx_d = '0;
      best_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StAccum: begin
          cnt_inc = spike_valid_i && spike_i;
          if (end_i) begin
            state_d    = StScan;
            ptr_d      = '0;
            best_idx_d = '0;
            best_cnt_d = '0;
          end
        end
        StScan: begin
          if (ptr_q == PTR_W'(NUM_OUTPUTS)) begin
            state_d = StDone;
          end else begin
            // Strict compare keeps the lowest index on ties.
            if (scan_count > best_cnt_q) begin
              best_cnt_d = scan_count;
              best_idx_d = ptr_q[IDX_W-1:0];
            end
            ptr_d = ptr_q + PTR_W'(1);
          end
        end
        StDone: begin
          if (result_ready_i) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign busy_o         = (state_q == StAccum) || (state_q == StScan);
  assign result_valid_o = (state_q == StDone);
  assign result_class_o = best_idx_q;
  assign result_count_o = best_cnt_q;

endmodule

// File: tb/tb_spike_decoder.sv
// Directed self-checking bench for spike_decoder with hand-computed expected results.
module tb_spike_decoder;

  localparam int unsigned NumOutputs = 10;
  localparam int unsigned IdxW       = 4;
  localparam int unsigned CntW       = 8;
  localparam int          Latency    = NumOutputs + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            spike_valid = 1'b0;
  logic            spike = 1'b0;
  logic [IdxW-1:0] spike_idx = '0;
  logic            end_win = 1'b0;
  logic            busy;
  logic            result_valid;
  logic            result_ready = 1'b0;
  logic [IdxW-1:0] result_class;
  logic [CntW-1:0] result_count;
`ifdef SPIKE_DECODER_COUNT_READ_EN
  logic [IdxW-1:0] rd_idx = '0;
  logic [CntW-1:0] rd_count;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  spike_decoder #(
    .NUM_OUTPUTS (NumOutputs),
    .IDX_W       (IdxW),
    .CNT_W       (CntW)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .start_i        (start),
    .spike_valid_i  (spike_valid),
    .spike_i        (spike),
    .spike_idx_i    (spike_idx),
    .end_i          (end_win),
    .busy_o         (busy),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .result_class_o (result_class),
    .result_count_o (result_count)
`ifdef SPIKE_DECODER_COUNT_READ_EN
    ,
    .rd_idx_i       (rd_idx),
    .rd_count_o     (rd_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_window();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_spikes(input logic [IdxW-1:0] idx, input int n, input logic bit_val);
    spike_valid = 1'b1;
    spike       = bit_val;
    spike_idx   = idx;
    repeat (n) tick();
    spike_valid = 1'b0;
    spike       = 1'b0;
  endtask

  // Pulses end_i (optionally with a coincident spike) and checks result latency.
  task automatic close_window(input logic with_spike, input logic [IdxW-1:0] sidx);
    int lat;
    end_win     = 1'b1;
    spike_valid = with_spike;
    spike       = with_spike;
    spike_idx   = sidx;
    tick();
    end_win     = 1'b0;
    spike_valid = 1'b0;
    spike       = 1'b0;
    lat = 999;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (result_valid) begin
        lat = i;
        break;
      end
    end
    check("latency", lat, Latency);
  endtask

  task automatic accept();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("valid_after_accept", result_valid, 0);
    check("busy_after_accept", busy, 0);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_class", result_class, 0);
    check("rst_count", result_count, 0);

    // Basic window, including ignored spike_i=0 qualifiers.
    start_window();
    check("busy_accum", busy, 1);
    send_spikes(4'd3, 5, 1'b1);
    send_spikes(4'd4, 3, 1'b0);
    send_spikes(4'd7, 2, 1'b1);
    close_window(1'b0, 4'd0);
    check("basic_class", result_class, 3);
    check("basic_count", result_count, 5);
    check("basic_busy_done", busy, 0);
`ifdef SPIKE_DECODER_COUNT_READ_EN
    rd_idx = 4'd3;  #1 check("rd_idx3", rd_count, 5);
    rd_idx = 4'd7;  #1 check("rd_idx7", rd_count, 2);
    rd_idx = 4'd15; #1 check("rd_idx15", rd_count, 0);
`endif
    accept();

    // Tie resolves to lowest index.
    start_window();
    send_spikes(4'd6, 4, 1'b1);
    send_spikes(4'd2, 4, 1'b1);
    close_window(1'b0, 4'd0);
    check("tie_class", result_class, 2);
    check("tie_count", result_count, 4);
    accept();

    // Empty window.
    start_window();
    close_window(1'b0, 4'd0);
    check("empty_class", result_class, 0);
    check("empty_count", result_count, 0);
    accept();

    // Saturation plus out-of-range indices.
    start_window();
    send_spikes(4'd1, 300, 1'b1);
    send_spikes(4'd12, 5, 1'b1);
    close_window(1'b0, 4'd0);
    check("sat_class", result_class, 1);
    check("sat_count", result_count, 255);
`ifdef SPIKE_DECODER_COUNT_READ_EN
    for (int i = 0; i < int'(NumOutputs); i++) begin
      rd_idx = IdxW'(i);
      #1 check($sformatf("sat_rd%0d", i), rd_count, (i == 1) ? 255 : 0);
    end
`endif
    accept();

    // Only out-of-range spikes: nothing counted.
    start_window();
    send_spikes(4'd12, 3, 1'b1);
    send_spikes(4'd15, 2, 1'b1);
    close_window(1'b0, 4'd0);
    check("oor_class", result_class, 0);
    check("oor_count", result_count, 0);
    accept();

    // Backpressure hold.
    start_window();
    send_spikes(4'd5, 3, 1'b1);
    close_window(1'b0, 4'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_valid", result_valid, 1);
      check("hold_class", result_class, 5);
      check("hold_count", result_count, 3);
    end
    accept();

    // end_i and spikes while idle are ignored.
    end_win = 1'b1;
    send_spikes(4'd2, 2, 1'b1);
    end_win = 1'b0;
    tick();
    check("idle_end_busy", busy, 0);
    check("idle_end_valid", result_valid, 0);

    // Start mid-scan aborts; counters are cleared for the new window.
    start_window();
    send_spikes(4'd4, 6, 1'b1);
    end_win = 1'b1;
    tick();
    end_win = 1'b0;
    repeat (3) tick();
    start_window();
    check("abort_busy", busy, 1);
    check("abort_valid", result_valid, 0);
    repeat (15) tick();
    check("abort_no_result", result_valid, 0);
    send_spikes(4'd3, 5, 1'b1);
    send_spikes(4'd7, 2, 1'b1);
    close_window(1'b0, 4'd0);
    check("abort_class", result_class, 3);
    check("abort_count", result_count, 5);
    accept();

    // Spike coincident with end_i is counted.
    start_window();
    send_spikes(4'd8, 2, 1'b1);
    send_spikes(4'd0, 2, 1'b1);
    close_window(1'b1, 4'd8);
    check("coinc_class", result_class, 8);
    check("coinc_count", result_count, 3);
    accept();

    // start_i with end_i restarts the window and clears counters.
    start_window();
    send_spikes(4'd2, 1, 1'b1);
    start   = 1'b1;
    end_win = 1'b1;
    tick();
    start   = 1'b0;
    end_win = 1'b0;
    check("startend_busy", busy, 1);
    repeat (12) tick();
    check("startend_still_accum", result_valid, 0);
    close_window(1'b0, 4'd0);
    check("startend_class", result_class, 0);
    check("startend_count", result_count, 0);
    accept();

    // Reset in DONE clears all outputs.
    start_window();
    send_spikes(4'd9, 1, 1'b1);
    close_window(1'b0, 4'd0);
    check("pre_rst_class", result_class, 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("done_rst_valid", result_valid, 0);
    check("done_rst_busy", busy, 0);
    check("done_rst_class", result_class, 0);
    check("done_rst_count", result_count, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
